pq_shift_reg: RTL and testbench

Parametrised shift-register hardware priority queue holding up to CAPACITY `<key,value>` entries. Entries are kept sorted by ascending key, with the minimum key at the head, and every operation completes in a single clock. This is the first storage implementation built on the shared `pq_pkg` types. It serves as the baseline against which later HWPQ variants are compared.

---
 rtl/pq_pkg.sv | 28 ++
 rtl/pq_cell.sv | 62 ++++++
 rtl/pq_shift_reg.sv | 119 +++++++++++
 tb/tb_pq_shift_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the hardware priority queue family.
// Key/value widths, the reserved empty-key marker and the per-cycle
// operation encoding used by the storage cells.
package pq_pkg;

   localparam int KEY_WIDTH   = 4;
   localparam int VAL_WIDTH   = 4;
   localparam int PQ_CAPACITY = 4;

   typedef struct packed {
      logic [KEY_WIDTH-1:0] key;
      logic [VAL_WIDTH-1:0] val;
   } kv_t;

   // All-ones key is reserved: it marks an unused slot and always sorts last.
   localparam logic [KEY_WIDTH-1:0] KEYINF   = {KEY_WIDTH{1'b1}};
   localparam logic [VAL_WIDTH-1:0] VAL0     = {VAL_WIDTH{1'b0}};
   localparam kv_t                  KV_EMPTY = '{key: KEYINF, val: VAL0};

   // Operation actually applied to the slot array this cycle (after legality checks).
   typedef enum logic [1:0] {
      NOP  = 2'd0,
      ENQ  = 2'd1,
      DEQ  = 2'd2,
      REPL = 2'd3
   } pq_op_t;

endpackage

// File: rtl/pq_cell.sv
// One slot of the shift-register priority queue.
// Decides locally, from its neighbours and the incoming entry, whether to
// hold, shift from the left, shift from the right or capture the new entry.
module pq_cell
   import pq_pkg::*;
#(
   parameter bit IS_HEAD = 1'b0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  pq_op_t op,
   input  kv_t    kvi,
   input  kv_t    kv_left,
   input  kv_t    kv_right,
   input  logic   lt_left,
   output kv_t    kv_out,
   output logic   lt_out
);

   kv_t  r_kv;
   kv_t  w_kv_next;
   logic w_lt;
   logic w_ge_right;

   // Strict less-than keeps a new entry behind any equal keys (FIFO among ties).
   assign w_lt       = (kvi.key < r_kv.key);
   assign w_ge_right = (kvi.key >= kv_right.key);

   // Next-slot selection; "not less than me" doubles as the left neighbour's
   // ge condition during a replace.
   always_comb begin
      w_kv_next = r_kv;
      case (op)
         ENQ: begin
            if (lt_left)
               w_kv_next = kv_left;
            else if (w_lt)
               w_kv_next = kvi;
         end
         DEQ: w_kv_next = kv_right;
         REPL: begin
            if (w_ge_right)
               w_kv_next = kv_right;
            else if (IS_HEAD || !w_lt)
               w_kv_next = kvi;
         end
         default: w_kv_next = r_kv;
      endcase
   end

   // Slot register, emptied by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_kv <= KV_EMPTY;
      else
         r_kv <= w_kv_next;
   end

   assign kv_out = r_kv;
   assign lt_out = w_lt;

endmodule

// File: rtl/pq_shift_reg.sv
// Shift-register hardware priority queue: CAPACITY sorted slots, minimum key
// at the head, one operation per clock. Optional sticky error flags are
// compiled in when PQ_ERR_EN is defined.
module pq_shift_reg
   import pq_pkg::*;
#(
   parameter int CAPACITY = PQ_CAPACITY
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enq,
   input  logic                          deq,
   input  kv_t                           kvi,
`ifdef PQ_ERR_EN
   input  logic                          err_clr,
   output logic [2:0]                    err,
`endif
   output kv_t                           kvo,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(CAPACITY+1)-1:0] count
);

   localparam int CNT_W = $clog2(CAPACITY+1);

   logic [CNT_W-1:0] r_count;
   pq_op_t           w_op;
   logic             w_key_ok;
   logic             w_full;
   logic             w_empty;
   kv_t              w_kv [0:CAPACITY];
   logic             w_lt [0:CAPACITY];

   assign w_full   = (r_count == CNT_W'(CAPACITY));
   assign w_empty  = (r_count == '0);
   assign w_key_ok = (kvi.key != KEYINF);

   // Reduce the request to the operation that is legal in the current state.
   always_comb begin
      w_op = NOP;
      if (enq && deq) begin
         if (!w_empty)
            w_op = w_key_ok ? REPL : DEQ;
         else
            w_op = w_key_ok ? ENQ : NOP;
      end else if (enq) begin
         w_op = (w_key_ok && !w_full) ? ENQ : NOP;
      end else if (deq) begin
         w_op = w_empty ? NOP : DEQ;
      end
   end

   // Virtual slot past the tail and the compare result left of the head.
   assign w_kv[CAPACITY] = KV_EMPTY;
   assign w_lt[0]        = 1'b0;

   generate
      for (genvar gi = 0; gi < CAPACITY; gi++) begin : g_cell
         kv_t w_left;
         if (gi == 0) begin : g_head
            assign w_left = KV_EMPTY;
         end else begin : g_body
            assign w_left = w_kv[gi-1];
         end
         pq_cell #(
            .IS_HEAD (gi == 0)
         ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .op       (w_op),
            .kvi      (kvi),
            .kv_left  (w_left),
            .kv_right (w_kv[gi+1]),
            .lt_left  (w_lt[gi]),
            .kv_out   (w_kv[gi]),
            .lt_out   (w_lt[gi+1])
         );
      end
   endgenerate

   // Occupancy tracks the applied operation; replace leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (w_op == ENQ)
         r_count <= r_count + 1'b1;
      else if (w_op == DEQ)
         r_count <= r_count - 1'b1;
   end

`ifdef PQ_ERR_EN
   logic [2:0] r_err;
   logic       w_ovf;
   logic       w_udf;
   logic       w_badkey;

   assign w_ovf    = enq && !deq && w_full;
   assign w_udf    = deq && w_empty;
   assign w_badkey = enq && !w_key_ok;

   // Sticky {badkey, udf, ovf}; a clear wins over a same-cycle set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err <= '0;
      else if (err_clr)
         r_err <= '0;
      else
         r_err <= r_err | {w_badkey, w_udf, w_ovf};
   end

   assign err = r_err;
`endif

   assign kvo   = w_kv[0];
   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;

endmodule

// File: tb/tb_pq_shift_reg.sv
// Self-checking bench for pq_shift_reg: directed scenarios followed by random
// traffic, each compared against a sorted-queue reference model.
// Error-flag checks are active when PQ_ERR_EN is defined.
module tb_pq_shift_reg;
   import pq_pkg::*;

   localparam int CAP = 4;

   logic       clk;
   logic       rst_n;
   logic       enq;
   logic       deq;
   kv_t        kvi;
   kv_t        kvo;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       err_clr;
   logic [2:0] err;

   int n_checks = 0;
   int n_errors = 0;

   kv_t        m_q[$];
   logic [2:0] m_err;

   pq_shift_reg #(.CAPACITY(CAP)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enq     (enq),
      .deq     (deq),
      .kvi     (kvi),
`ifdef PQ_ERR_EN
      .err_clr (err_clr),
      .err     (err),
`endif
      .kvo     (kvo),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

`ifndef PQ_ERR_EN
   assign err = 3'b000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference insert: new entry goes after every entry with key <= its key.
   task automatic model_insert(input kv_t kv);
      int idx;
      idx = m_q.size();
      for (int i = 0; i < m_q.size(); i++) begin
         if (m_q[i].key > kv.key) begin
            idx = i;
            break;
         end
      end
      m_q.insert(idx, kv);
   endtask

   task automatic model_step(input logic e, input logic d, input kv_t kv, input logic clr);
      logic bad;
      logic ovf;
      logic udf;
      bad = e && (kv.key == KEYINF);
      ovf = e && !d && (m_q.size() == CAP);
      udf = d && (m_q.size() == 0);
      if (e && d) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         if (!bad) model_insert(kv);
      end else if (e) begin
         if (!bad && m_q.size() < CAP) model_insert(kv);
      end else if (d) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
      end
      if (clr) m_err = 3'b000;
      else     m_err = m_err | {bad, udf, ovf};
   endtask

   task automatic check_outputs(input string tag);
      kv_t exp_kv;
      exp_kv = (m_q.size() > 0) ? m_q[0] : KV_EMPTY;
      check({tag, ".kvo"},   int'(kvo),   int'(exp_kv));
      check({tag, ".count"}, int'(count), m_q.size());
      check({tag, ".full"},  int'(full),  int'(m_q.size() == CAP));
      check({tag, ".empty"}, int'(empty), int'(m_q.size() == 0));
`ifdef PQ_ERR_EN
      check({tag, ".err"},   int'(err),   int'(m_err));
`endif
   endtask

   task automatic do_op(input string tag, input logic e, input logic d, input kv_t kv,
                        input logic clr);
      @(negedge clk);
      enq     = e;
      deq     = d;
      kvi     = kv;
      err_clr = clr;
      @(posedge clk);
      #1;
      model_step(e, d, kv, clr);
      $display("op %s enq=%0d deq=%0d kvi=%02h clr=%0d -> kvo=%02h count=%0d err=%0b",
               tag, e, d, kv, clr, kvo, count, err);
      check_outputs(tag);
   endtask

   function automatic kv_t mk(input int k, input int v);
      kv_t r;
      r.key = 4'(k);
      r.val = 4'(v);
      return r;
   endfunction

   initial begin
      rst_n   = 1'b0;
      enq     = 1'b0;
      deq     = 1'b0;
      kvi     = KV_EMPTY;
      err_clr = 1'b0;
      m_err   = 3'b000;
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic ordering and draining.
      do_op("enq3A", 1, 0, mk(3, 4'hA), 0);
      do_op("enq1B", 1, 0, mk(1, 4'hB), 0);
      do_op("enq2C", 1, 0, mk(2, 4'hC), 0);
      check("head_after_3", int'(kvo), int'(mk(1, 4'hB)));
      do_op("deq1", 0, 1, KV_EMPTY, 0);
      do_op("deq2", 0, 1, KV_EMPTY, 0);
      do_op("deq3", 0, 1, KV_EMPTY, 0);
      check("drained_kvo", int'(kvo), int'(mk(15, 0)));

      // FIFO among equal keys.
      do_op("tie1", 1, 0, mk(5, 1), 0);
      do_op("tie2", 1, 0, mk(5, 2), 0);
      do_op("tie3", 1, 0, mk(5, 3), 0);
      check("tie_head_val", int'(kvo.val), 1);
      do_op("tied1", 0, 1, KV_EMPTY, 0);
      check("tie_second_val", int'(kvo.val), 2);
      do_op("tied2", 0, 1, KV_EMPTY, 0);
      do_op("tied3", 0, 1, KV_EMPTY, 0);

      // Full queue: overflow is ignored, replace is legal.
      do_op("fill1", 1, 0, mk(1, 1), 0);
      do_op("fill4", 1, 0, mk(4, 2), 0);
      do_op("fill6", 1, 0, mk(6, 3), 0);
      do_op("fill8", 1, 0, mk(8, 4), 0);
      do_op("ovf",   1, 0, mk(2, 5), 0);
      check("ovf_full", int'(full), 1);
      do_op("repl7", 1, 1, mk(7, 9), 0);
      check("repl7_head", int'(kvo.key), 4);
      do_op("dr1", 0, 1, KV_EMPTY, 0);
      do_op("dr2", 0, 1, KV_EMPTY, 0);
      check("repl7_third", int'(kvo), int'(mk(7, 9)));
      do_op("dr3", 0, 1, KV_EMPTY, 0);
      do_op("dr4", 0, 1, KV_EMPTY, 0);

      // Underflow, clear, reserved key.
      do_op("udf",    0, 1, KV_EMPTY, 0);
      do_op("clr",    0, 0, KV_EMPTY, 1);
      do_op("badkey", 1, 0, mk(15, 3), 0);
      do_op("clr2",   0, 0, KV_EMPTY, 1);

      // Replace on single entry; enq+deq while empty.
      do_op("one2",   1, 0, mk(2, 1), 0);
      do_op("repl0",  1, 1, mk(0, 5), 0);
      do_op("dr0",    0, 1, KV_EMPTY, 0);
      do_op("ed66",   1, 1, mk(6, 6), 0);
      check("ed66_kvo", int'(kvo), int'(mk(6, 6)));
      do_op("badrepl", 1, 1, mk(15, 7), 0);
      do_op("clr3",   0, 0, KV_EMPTY, 1);

      // Asynchronous reset between edges with three entries queued.
      do_op("pre1", 1, 0, mk(9, 1), 0);
      do_op("pre2", 1, 0, mk(3, 2), 0);
      do_op("pre3", 1, 0, mk(7, 3), 0);
      @(negedge clk);
      enq = 1'b0;
      deq = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      m_q.delete();
      m_err = 3'b000;
      $display("op async_reset -> kvo=%02h count=%0d", kvo, count);
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post", 1, 0, mk(4, 4), 0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         logic e;
         logic d;
         logic c;
         int   k;
         e = ($urandom_range(0, 99) < 55);
         d = ($urandom_range(0, 99) < 45);
         c = ($urandom_range(0, 99) < 5);
         k = ($urandom_range(0, 99) < 6) ? 15 : $urandom_range(0, 14);
         do_op($sformatf("rnd%0d", n), e, d, mk(k, $urandom_range(0, 15)), c);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
